mux_tree_pipe: RTL and testbench

Parametrised N:1 multiplexer built as a registered binary tree of 2:1 cells, one pipeline register per tree level. It supersedes the fixed 7:1 combinational mux-from-2:1 structure. It adds data width, valid tracking, an aligned select and error report, and an auto-scan mode in which an internal counter steps the select across all inputs. It sits in the dataflow library as the reusable selector for multi-channel sampling paths.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_tree_pipe_if.sv | 30 +++
 rtl/mux2_reg.sv | 22 ++
 rtl/mux_tree_pipe.sv | 98 +++++++++
 tb/tb_mux_tree_pipe.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined mux tree.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Sample/select bus for mux_tree_pipe; master drives samples, slave is the mux.
interface mux_tree_pipe_if
  import mux_pkg::*;
#(
  parameter int unsigned N = 7,
  parameter int unsigned W = 1
);

  localparam int unsigned SW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [N*W-1:0] in_data;
  logic [SW-1:0]  sel;
  logic           in_valid;
  logic           mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_sel;
  logic           sel_err;

  modport master (
    output in_data, sel, in_valid, mode,
    input  out_data, out_valid, out_sel, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, mode,
    output out_data, out_valid, out_sel, sel_err
  );

endinterface

// File: rtl/mux2_reg.sv
// W-bit 2:1 mux with registered output; s_i=1 selects b_i.
module mux2_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         s_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= s_i ? b_i : a_i;
  end

  assign y_o = y_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// N:1 registered binary mux tree, one register per level, with manual or
// auto-scan select and a side-band pipe carrying select/valid/error.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int unsigned N = 7,
  parameter int unsigned W = 1
) (
  input logic            clk,
  input logic            rst_n,
  mux_tree_pipe_if.slave bus
);

  localparam int unsigned SW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int unsigned L  = SW;
  localparam int unsigned P  = 1 << SW;
  localparam logic [SW-1:0] LAST  = SW'(N - 1);
  localparam logic [SW:0]   N_EXT = (SW + 1)'(N);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [SW-1:0] eff_sel;
  logic          eff_err;

  logic [SW-1:0] sel_q [L];
  logic          vld_q [L];
  logic          err_q [L];

  // Heap-ordered node storage: node 0 is the root, leaves start at P-1.
  logic [(2*P-1)*W-1:0] tree;

  always_comb begin
    eff_sel    = (bus.mode == MODE_SCAN) ? scan_cnt_q : bus.sel;
    eff_err    = ({1'b0, eff_sel} >= N_EXT);
    scan_cnt_d = scan_cnt_q;
    if (bus.mode == MODE_MANUAL) begin
      scan_cnt_d = '0;
    end else if (bus.in_valid) begin
      scan_cnt_d = (scan_cnt_q == LAST) ? '0 : scan_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      for (int unsigned s = 0; s < L; s++) begin
        sel_q[s] <= '0;
        vld_q[s] <= 1'b0;
        err_q[s] <= 1'b0;
      end
    end else begin
      scan_cnt_q <= scan_cnt_d;
      sel_q[0]   <= eff_sel;
      vld_q[0]   <= bus.in_valid;
      err_q[0]   <= eff_err;
      for (int unsigned s = 1; s < L; s++) begin
        sel_q[s] <= sel_q[s-1];
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
      end
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < N) begin : g_in
      assign tree[(P-1+k)*W +: W] = bus.in_data[k*W +: W];
    end else begin : g_pad
      assign tree[(P-1+k)*W +: W] = '0;
    end
  end

  // Level j consumes select bit j, delayed j cycles to stay aligned with data.
  for (genvar j = 0; j < L; j++) begin : g_lvl
    localparam int unsigned CELLS = P >> (j + 1);
    logic s_bit;
    if (j == 0) begin : g_s0
      assign s_bit = eff_sel[0];
    end else begin : g_sn
      assign s_bit = sel_q[j-1][j];
    end
    for (genvar k = 0; k < CELLS; k++) begin : g_cell
      localparam int unsigned NODE = CELLS - 1 + k;
      mux2_reg #(.W(W)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (tree[(2*NODE+1)*W +: W]),
        .b_i   (tree[(2*NODE+2)*W +: W]),
        .s_i   (s_bit),
        .y_o   (tree[NODE*W +: W])
      );
    end
  end

  assign bus.out_valid = vld_q[L-1];
  assign bus.out_sel   = sel_q[L-1];
  assign bus.sel_err   = err_q[L-1];
  assign bus.out_data  = err_q[L-1] ? '0 : tree[W-1:0];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench: two mux_tree_pipe sizes driven with directed and random samples.
module tb_mux_tree_pipe;

  localparam int unsigned NA = 7;
  localparam int unsigned WA = 1;
  localparam int unsigned LA = 3;
  localparam int unsigned NB = 16;
  localparam int unsigned WB = 8;
  localparam int unsigned LB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_tree_pipe_if #(.N(NA), .W(WA)) a_if ();
  mux_tree_pipe_if #(.N(NB), .W(WB)) b_if ();

  mux_tree_pipe #(.N(NA), .W(WA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  mux_tree_pipe #(.N(NB), .W(WB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  typedef struct {
    logic [7:0] d;
    logic [4:0] s;
    logic       e;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scan_a = 0;
  int scan_b = 0;
  bit mon_en = 0;

  logic [NA*WA-1:0] da;
  logic [NB*WB-1:0] db;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: effective select from mode rules, data picked by plain indexing.
  task automatic issue_a(input bit m, input bit v, input int s);
    int eff;
    exp_t e;
    eff = m ? scan_a : s;
    a_if.mode = m;
    a_if.in_valid = v;
    a_if.sel = 3'(s);
    a_if.in_data = da;
    if (v) begin
      e.s = 5'(eff);
      e.e = (eff >= NA);
      e.d = e.e ? 8'h00 : 8'(da[eff*WA +: WA]);
      e.due = cyc + LA;
      qa.push_back(e);
    end
    if (!m) scan_a = 0;
    else if (v) scan_a = (scan_a + 1) % NA;
  endtask

  task automatic issue_b(input bit m, input bit v, input int s);
    int eff;
    exp_t e;
    eff = m ? scan_b : s;
    b_if.mode = m;
    b_if.in_valid = v;
    b_if.sel = 4'(s);
    b_if.in_data = db;
    if (v) begin
      e.s = 5'(eff);
      e.e = (eff >= NB);
      e.d = e.e ? 8'h00 : 8'(db[eff*WB +: WB]);
      e.due = cyc + LB;
      qb.push_back(e);
    end
    if (!m) scan_b = 0;
    else if (v) scan_b = (scan_b + 1) % NB;
  endtask

  task automatic step(input bit am, input bit av, input int as,
                      input bit bm, input bit bv, input int bs);
    issue_a(am, av, as);
    issue_b(bm, bv, bs);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero;
    chk("A_rst_valid", int'(a_if.out_valid), 0);
    chk("A_rst_data",  int'(a_if.out_data), 0);
    chk("A_rst_sel",   int'(a_if.out_sel), 0);
    chk("A_rst_err",   int'(a_if.sel_err), 0);
    chk("B_rst_valid", int'(b_if.out_valid), 0);
    chk("B_rst_data",  int'(b_if.out_data), 0);
    chk("B_rst_sel",   int'(b_if.out_sel), 0);
    chk("B_rst_err",   int'(b_if.sel_err), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front();
        chk("A_valid", int'(a_if.out_valid), 1);
        chk("A_data",  int'(a_if.out_data), int'(ea.d));
        chk("A_sel",   int'(a_if.out_sel), int'(ea.s));
        chk("A_err",   int'(a_if.sel_err), int'(ea.e));
      end else begin
        chk("A_idle_valid", int'(a_if.out_valid), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (qb.size() > 0 && qb[0].due == cyc) begin
        eb = qb.pop_front();
        chk("B_valid", int'(b_if.out_valid), 1);
        chk("B_data",  int'(b_if.out_data), int'(eb.d));
        chk("B_sel",   int'(b_if.out_sel), int'(eb.s));
        chk("B_err",   int'(b_if.sel_err), int'(eb.e));
      end else begin
        chk("B_idle_valid", int'(b_if.out_valid), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ma, mb;
    da = 7'b0110001;
    for (int k = 0; k < 16; k++) db[k*8 +: 8] = 8'(8'h10 + k);
    issue_a(0, 0, 0);
    issue_b(0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check_zero();
    rst_n = 1'b1;
    mon_en = 1;

    // manual walk, B held on sel=13
    for (int i = 0; i < 7; i++) step(0, 1, i, 0, 1, 13);
    // out of range select
    step(0, 1, 7, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);

    // auto-scan with wrap
    repeat (8) step(1, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // scan hold on idle, then manual clears the counter
    repeat (3) step(1, 1, 0, 1, 1, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 1, 1, 0);

    // B full scan wrap 15 -> 0
    step(0, 0, 0, 0, 0, 0);
    repeat (17) step(0, 0, 0, 1, 1, 0);

    // randomized traffic with sticky modes
    ma = 0;
    mb = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) ma = !ma;
      if ($urandom_range(0, 9) == 0) mb = !mb;
      if ($urandom_range(0, 7) == 0) begin
        da = 7'($urandom);
        db = {$urandom, $urandom, $urandom, $urandom};
      end
      step(ma, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
           mb, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
    end
    repeat (6) step(0, 0, 0, 0, 0, 0);

    // async reset with three samples in flight
    da = 7'b0110001;
    for (int k = 0; k < 16; k++) db[k*8 +: 8] = 8'(8'h10 + k);
    step(0, 1, 5, 0, 1, 9);
    step(0, 1, 6, 0, 1, 10);
    issue_a(0, 1, 3);
    issue_b(0, 1, 11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero();
    qa.delete();
    qb.delete();
    scan_a = 0;
    scan_b = 0;
    issue_a(0, 0, 0);
    issue_b(0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 0, 1, 15);
    repeat (6) step(0, 0, 0, 0, 0, 0);

    chk("A_drained", qa.size(), 0);
    chk("B_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
